// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder that writes encoded words into instruction memory
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_sel,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  localparam logic [1:0] OP_ADDI = 2'd0;
  localparam logic [1:0] OP_SW   = 2'd1;
  localparam logic [1:0] OP_LW   = 2'd2;
  localparam logic [1:0] OP_JALR = 2'd3;

  logic [0:0]       state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [31:0] enc_word;
  logic        imm_oor;

  // Only the low 12 bits fit an I/S-type immediate; anything above is out of range.
  assign imm_oor = |imm[31:12];

  // Fields are only taken while idle; start steals the cycle, and reset blocks acceptance.
  assign in_ready = (state_q == IDLE) && !start && rst_n;

  // Combinational instruction encoding; fields a format does not use are simply not wired in.
  always_comb begin
    enc_word = '0;
    case (op_sel)
      OP_ADDI: enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      OP_SW:   enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_LW:   enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      OP_JALR: enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default: enc_word = '0;
    endcase
  end

  // Next-state logic: IDLE handles start/accept/range error, WRITE waits for the memory ack.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      if (start) begin
        addr_d  = base_addr;
        count_d = '0;
        err_d   = 1'b0;
      end else if (in_valid) begin
        if (imm_oor) begin
          err_d = 1'b1;
        end else begin
          wdata_d = enc_word;
          req_d   = 1'b1;
          state_d = WRITE;
        end
      end
    end else begin
      // Request, address and data stay frozen until the ack arrives; start is ignored here.
      if (mem_ack) begin
        req_d   = 1'b0;
        addr_d  = addr_q + 32'd4;
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d = IDLE;
      end
    end
  end

  // State registers with synchronous active-low reset; a reset mid-write drops the write uncounted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule
